// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, word-length codes and controlReg field layout.
// Used by both the transmitter and the receiver so their frame formats stay identical.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SEND = 2'b10,
        DONE = 2'b11
    } uartState_e;

    typedef enum logic [1:0] {
        WLEN5 = 2'd0,
        WLEN6 = 2'd1,
        WLEN7 = 2'd2,
        WLEN8 = 2'd3
    } wordLen_e;

    localparam int unsigned CR_WIDTH       = 6;
    localparam int unsigned CR_WLEN        = 0;  // two-bit field [1:0]
    localparam int unsigned CR_STOP        = 2;
    localparam int unsigned CR_PEN         = 3;
    localparam int unsigned CR_EPS         = 4;
    localparam int unsigned CR_SPAR        = 5;
    localparam int unsigned MAX_FRAME_BITS = 12;

    function automatic logic [7:0] dataMask(input logic [1:0] wlen);
        logic [7:0] mask;
        case (wordLen_e'(wlen))
            WLEN5:   mask = 8'h1F;
            WLEN6:   mask = 8'h3F;
            WLEN7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/uart_tx_frame_builder.sv
// Combinational frame assembly: start bit, data LSB first, optional parity, stop bits.
// Produces the shift-register image and the number of bit times in the frame.
module uart_tx_frame_builder
    import uart_pkg::*;
(
    input  logic [7:0]                data,
    input  logic [CR_WIDTH-1:0]       control,
    output logic [MAX_FRAME_BITS-1:0] frameImage,
    output logic [3:0]                bitCount
);

    logic [7:0] mask;
    logic [3:0] nBits;
    logic       parity;
    logic       pen;

    always_comb begin
        mask   = dataMask(control[CR_WLEN +: 2]);
        nBits  = 4'd5 + {2'b00, control[CR_WLEN +: 2]};
        pen    = control[CR_PEN];
        // Computed parity is even when EPS=1; stick mode drives the inverse of EPS.
        parity = control[CR_SPAR] ? ((^(data & mask)) ^ ~control[CR_EPS]) : ~control[CR_EPS];

        // Start from all ones so the stop bits and unused slots are already marking.
        frameImage    = '1;
        frameImage[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                frameImage[i + 1] = data[i];
            end
        end
        if (pen) begin
            frameImage[nBits + 4'd1] = parity;
        end

        bitCount = 4'd2 + nBits + {3'b000, pen} + {3'b000, control[CR_STOP]};
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO onto uartTxLine.
// Define UART_TX_CTS_EN to add the active-low ctsN flow-control input.
module uart_tx
    import uart_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                baudRateX16Tick,
    input  logic [CR_WIDTH-1:0] controlReg,
    input  logic                sendBreak,
    input  logic                fifoEmpty,
    input  logic [7:0]          fifoData,
`ifdef UART_TX_CTS_EN
    input  logic                ctsN,
`endif
    output logic                fifoRe,
    output logic                uartTxLine,
    output logic                busy,
    output logic                txEmpty
);

    uartState_e                stateQ, stateD;
    logic [MAX_FRAME_BITS-1:0] shiftQ, shiftD;
    logic [3:0]                bitCntQ, bitCntD;
    logic [3:0]                baudCntQ, baudCntD;
    logic                      fifoReD, lineD, busyD;
    logic [MAX_FRAME_BITS-1:0] frameImage;
    logic [3:0]                loadCount;
    logic                      ctsOk;
    logic                      bitTick;

`ifdef UART_TX_CTS_EN
    logic [1:0] ctsSync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctsSync <= 2'b11;
        end else begin
            ctsSync <= {ctsSync[0], ctsN};
        end
    end

    assign ctsOk = ~ctsSync[1];
`else
    assign ctsOk = 1'b1;
`endif

    uart_tx_frame_builder u_frameBuilder (
        .data       (fifoData),
        .control    (controlReg),
        .frameImage (frameImage),
        .bitCount   (loadCount)
    );

    assign bitTick = baudRateX16Tick && (baudCntQ == 4'hF);
    assign txEmpty = (stateQ == IDLE) && fifoEmpty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: if (!fifoEmpty && ctsOk) stateD = LOAD;
            LOAD: stateD = SEND;
            SEND: if (bitTick && (bitCntQ == 4'd1)) stateD = DONE;
            DONE: stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        shiftD   = shiftQ;
        bitCntD  = bitCntQ;
        baudCntD = baudCntQ;
        unique case (stateQ)
            LOAD: begin
                shiftD   = frameImage;
                bitCntD  = loadCount;
                baudCntD = 4'd0;
            end
            SEND: begin
                if (baudRateX16Tick) begin
                    baudCntD = baudCntQ + 4'd1;
                    if (baudCntQ == 4'hF) begin
                        shiftD  = {1'b1, shiftQ[MAX_FRAME_BITS-1:1]};
                        bitCntD = bitCntQ - 4'd1;
                    end
                end
            end
            default: ;
        endcase
        // Outputs are computed from next state so the registered copies line up with it.
        fifoReD = (stateQ == IDLE) && (stateD == LOAD);
        busyD   = (stateD != IDLE);
        lineD   = ~sendBreak && ((stateD == SEND) ? shiftD[0] : 1'b1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shiftQ     <= '1;
            bitCntQ    <= 4'd0;
            baudCntQ   <= 4'd0;
            fifoRe     <= 1'b0;
            busy       <= 1'b0;
            uartTxLine <= 1'b1;
        end else begin
            shiftQ     <= shiftD;
            bitCntQ    <= bitCntD;
            baudCntQ   <= baudCntD;
            fifoRe     <= fifoReD;
            busy       <= busyD;
            uartTxLine <= lineD;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame formats, back-to-back frames, break, async reset.
// Builds with or without UART_TX_CTS_EN.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       baudRateX16Tick;
    logic [5:0] controlReg;
    logic       sendBreak;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoRe;
    logic       uartTxLine;
    logic       busy;
    logic       txEmpty;
`ifdef UART_TX_CTS_EN
    logic       ctsN;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] fifoMem [16];
    int wrPtr    = 0;
    int rdPtr    = 0;
    int popCount = 0;
    int badPop   = 0;

    always #5 clock = ~clock;

    uart_tx dut (
        .clock           (clock),
        .reset           (reset),
        .baudRateX16Tick (baudRateX16Tick),
        .controlReg      (controlReg),
        .sendBreak       (sendBreak),
        .fifoEmpty       (fifoEmpty),
        .fifoData        (fifoData),
`ifdef UART_TX_CTS_EN
        .ctsN            (ctsN),
`endif
        .fifoRe          (fifoRe),
        .uartTxLine      (uartTxLine),
        .busy            (busy),
        .txEmpty         (txEmpty)
    );

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoData  = fifoMem[rdPtr[3:0]];

    always @(posedge clock) begin
        if (fifoRe) begin
            popCount <= popCount + 1;
            if (fifoEmpty) badPop <= badPop + 1;
            else           rdPtr  <= rdPtr + 1;
        end
    end

    // One-cycle tick every 4 clocks.
    initial begin
        baudRateX16Tick = 1'b0;
        forever begin
            repeat (3) @(negedge clock);
            baudRateX16Tick = 1'b1;
            @(negedge clock);
            baudRateX16Tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifoMem[wrPtr % 16] = b;
        wrPtr = wrPtr + 1;
    endtask

    task automatic waitTicks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            while (baudRateX16Tick !== 1'b1) @(posedge clock);
        end
        #1;
    endtask

    // Waits for a start bit, then samples nBits bit centres; waitClk is the idle time seen.
    task automatic getFrame(input string tag, input int nBits, output logic [11:0] bits,
                            output int waitClk);
        int t;
        bits = '0;
        t    = 0;
        while (uartTxLine !== 1'b0 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        waitClk = t;
        if (uartTxLine !== 1'b0) begin
            checkVal({tag, "_start_timeout"}, 32'd0, 32'd1);
        end else begin
            waitTicks(8);
            bits[0] = uartTxLine;
            for (int i = 1; i < nBits; i++) begin
                waitTicks(16);
                bits[i] = uartTxLine;
            end
        end
    endtask

    logic [11:0] bits;
    int          gap;
    int          pops;
    int          ticks;
    int          guard;
    int          bad;

    initial begin
        reset      = 1'b0;
        controlReg = 6'h03;
        sendBreak  = 1'b0;
`ifdef UART_TX_CTS_EN
        ctsN       = 1'b0;
`endif
        repeat (3) @(negedge clock);
        checkVal("rst_line", uartTxLine, 1);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_fifoRe", fifoRe, 0);
        checkVal("rst_txEmpty", txEmpty, 1);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // 8N1, 0x55
        pops = popCount;
        push(8'h55);
        getFrame("8n1_55", 10, bits, gap);
        checkVal("8n1_55_frame", bits, 12'h2AA);
        ticks = 152;
        guard = 0;
        while (txEmpty !== 1'b1 && guard < 2000) begin
            @(posedge clock);
            if (baudRateX16Tick) ticks++;
            #1;
            guard++;
        end
        checkVal("8n1_55_ticks_to_txEmpty", ticks, 160);
        checkVal("8n1_55_pops", popCount - pops, 1);

        // 7E1
        controlReg = 6'h3A;
        push(8'h41);
        getFrame("7e1_41", 10, bits, gap);
        checkVal("7e1_41_frame", bits, 12'h282);
        push(8'h43);
        getFrame("7e1_43", 10, bits, gap);
        checkVal("7e1_43_frame", bits, 12'h386);

        // 5 bits, odd, 2 stop; then stick parity with data whose odd parity would be 1
        controlReg = 6'h2C;
        push(8'h1F);
        getFrame("5o2_1f", 9, bits, gap);
        checkVal("5o2_1f_frame", bits, 12'h1BE);
        controlReg = 6'h1C;
        push(8'h1E);
        getFrame("5s2_1e", 9, bits, gap);
        checkVal("5s2_1e_frame", bits, 12'h1BC);

        // Three back-to-back 8N1 frames
        controlReg = 6'h03;
        pops = popCount;
        push(8'hA5);
        push(8'h3C);
        push(8'h01);
        getFrame("b2b_a5", 10, bits, gap);
        checkVal("b2b_a5_frame", bits, 12'h34A);
        getFrame("b2b_3c", 10, bits, gap);
        checkVal("b2b_3c_frame", bits, 12'h278);
        checkVal("b2b_gap1_short", (gap >= 30 && gap <= 45), 1);
        getFrame("b2b_01", 10, bits, gap);
        checkVal("b2b_01_frame", bits, 12'h202);
        checkVal("b2b_gap2_short", (gap >= 30 && gap <= 45), 1);
        waitTicks(16);
        checkVal("b2b_pops", popCount - pops, 3);

        // Break mid-frame for 30 bit times
        pops = popCount;
        push(8'hFF);
        getFrame("brk_ff", 3, bits, gap);
        checkVal("brk_ff_head", bits, 12'h006);
        sendBreak = 1'b1;
        @(posedge clock);
        #1;
        checkVal("brk_next_cycle", uartTxLine, 0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            waitTicks(16);
            if (uartTxLine !== 1'b0) bad++;
        end
        checkVal("brk_line_high_samples", bad, 0);
        checkVal("brk_fsm_done_busy", busy, 0);
        checkVal("brk_fsm_done_txEmpty", txEmpty, 1);
        checkVal("brk_pops", popCount - pops, 1);
        sendBreak = 1'b0;
        @(posedge clock);
        #1;
        checkVal("brk_release_line", uartTxLine, 1);

        // Async reset during a data bit, then the queued byte goes out cleanly
        pops = popCount;
        push(8'h00);
        push(8'h96);
        getFrame("rst_00", 3, bits, gap);
        checkVal("rst_00_head", bits, 12'h000);
        reset = 1'b0;
        #1;
        checkVal("rst_async_line", uartTxLine, 1);
        checkVal("rst_async_busy", busy, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        getFrame("rst_96", 10, bits, gap);
        checkVal("rst_96_frame", bits, 12'h32C);
        checkVal("rst_pops", popCount - pops, 2);
        waitTicks(16);

`ifdef UART_TX_CTS_EN
        ctsN = 1'b1;
        pops = popCount;
        push(8'h5A);
        repeat (50) @(negedge clock);
        checkVal("cts_hold_pops", popCount - pops, 0);
        checkVal("cts_hold_line", uartTxLine, 1);
        checkVal("cts_hold_busy", busy, 0);
        ctsN = 1'b0;
        getFrame("cts_5a", 10, bits, gap);
        checkVal("cts_5a_frame", bits, 12'h2B4);
        checkVal("cts_pops", popCount - pops, 1);
        waitTicks(16);
`endif

        checkVal("no_pop_when_empty", badPop, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that pops bytes from a first-word-fall-through TX FIFO and serialises them onto the uartTxLine.
- Frame format: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits. All timing derives from the shared baudRateX16Tick.
- The frame encoding and controlReg layout mirror the UART receiver, so a TX-to-RX loopback is bit-exact.

Parameters:
- None. The frame format is runtime-programmable through controlReg.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- baudRateX16Tick  in  1  one-cycle strobe at 16x the baud rate.
- controlReg  in  6  [1:0] word length (0=5, 1=6, 2=7, 3=8 bits); [2] stop bits (0=1, 1=2); [3] parity enable; [4] even-parity select; [5] parity mode (1=computed, 0=stick).
- sendBreak  in  1  forces the line low while high.
- fifoEmpty  in  1  TX FIFO empty flag.
- fifoData  in  8  FIFO head word, valid whenever fifoEmpty=0.
- fifoRe  out  1  one-cycle pop strobe.
- uartTxLine  out  1  serial output, idle high.
- busy  out  1  high while a frame is being loaded or shifted.
- txEmpty  out  1  high when IDLE and fifoEmpty=1 (THRE/TEMT equivalent).

Behaviour:
- Reset (async): state=IDLE, uartTxLine=1, fifoRe=0, busy=0, txEmpty=1, counters=0.
- All outputs are registered, except txEmpty.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE -> LOAD when fifoEmpty=0; otherwise hold.
- LOAD (exactly one cycle):
  - fifoRe=1.
  - Capture fifoData and controlReg.
  - Build a 12-bit shift register as {stop bits (1s), parity, data[N-1:0], start 0}, LSB first.
  - Load bitCounter = 1 + N + P + S, where N = 5..8, P = controlReg[3], S = 1 + controlReg[2]. Range is 7..12.
  - Clear baudCounter.
  - Go to SEND.
- SEND:
  - uartTxLine = shiftReg[0].
  - baudCounter (4 bits) increments on each tick.
  - On a tick with baudCounter=15: shift right with fill 1, and decrement bitCounter.
  - When bitCounter reaches 0, go to DONE.
- DONE (one cycle): go to IDLE. A non-empty FIFO then re-enters LOAD, giving a 2-cycle inter-frame gap plus tick alignment. No idle bit is inserted beyond the stop bits.
- Bit duration: exactly 16 baudRateX16Tick strobes. The start bit begins at the clock edge after LOAD, so it is not tick-aligned; its first bit may be shortened by less than 1/16 bit.
- Parity, with D = XOR of the N data bits:
  - controlReg[5]=1: parity = D ^ ~controlReg[4], i.e. even parity when [4]=1, odd parity when [4]=0.
  - controlReg[5]=0 (stick): parity = ~controlReg[4].
  - Parity is only inserted when controlReg[3]=1.
- controlReg changes mid-frame take effect on the next LOAD only.
- sendBreak=1:
  - uartTxLine=0 from the next cycle.
  - The FSM continues, so frames in flight are consumed and lost.
  - On release, the line returns to shiftReg[0], or to 1 when IDLE.
- busy=1 in LOAD, SEND and DONE.
- fifoRe is never asserted while fifoEmpty=1.
- Reset mid-frame: the line returns high immediately and the frame is aborted. A byte already popped is discarded.

Optional Feature:
UART_TX_CTS_EN
- Defined:
  - Adds input ctsN (1 bit, active-low clear-to-send), passed through a 2-flop synchroniser.
  - IDLE -> LOAD additionally requires synchronised ctsN=0.
  - A frame in progress always completes regardless of ctsN.
- Undefined: no ctsN port; behaviour is as above.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE=2'b00, LOAD=2'b01, SEND=2'b10, DONE=2'b11).
  - Word-length codes.
  - controlReg bit-index constants (CR_WLEN, CR_STOP, CR_PEN, CR_EPS, CR_SPAR).
  - MAX_FRAME_BITS=12.
- The package is shared with the receiver.
- Sub-module uart_tx_frame_builder: combinational; takes data plus controlReg and produces shift-register image, bitCounter load value and parity.

Test Plan:
1. 8N1 (controlReg=6'h03), push 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each 16 ticks; fifoRe pulses once; txEmpty rises after 160 ticks.
2. 7E1 (controlReg=6'h3A), push 0x41 -> data 1,0,0,0,0,0,1; parity 0; one stop bit; frame length 10 bits. Repeat with 0x43 -> parity 1.
3. 5-bit, odd parity, 2 stop bits (controlReg=6'h2C), push 0x1F -> data 1,1,1,1,1; parity 0; stop 1,1; 9 bits total. Stick mode (6'h1C) -> parity 0 regardless of data.
4. Three bytes queued, 8N1 -> three back-to-back frames; exactly 3 fifoRe pulses; each frame carries no extra idle bit beyond its stop bit.
5. sendBreak asserted mid-frame for 30 bit times -> line stays 0; FSM completes; line returns high on release.
6. reset pulsed low mid-data-bit -> uartTxLine=1 and busy=0 asynchronously; after release with the FIFO non-empty, the next byte is sent cleanly. With UART_TX_CTS_EN: ctsN=1 holds the byte with fifoRe=0; ctsN=0 starts the frame.
